fft_butterfly: RTL and testbench
================================

Name: fft_butterfly

Overview:
- Pipelined radix-2 DIT butterfly; the datapath stage directly downstream of the twiddle ROM.
- Takes complex operands A and B plus the twiddle W read from the ROM.
- Produces X0 = (A + W·B)/2 and X1 = (A − W·B)/2, with per-stage scaling by 1/2 so the word size is preserved across FFT stages.
- The stage controller aligns data with ROM output: the ROM has 1-cycle read latency, so the controller delays data one cycle relative to the ROM address.

Parameters:
- word_size, 16, width of each real/imag component; signed two's complement Q1.(word_size−1).
- N, 32, FFT length; sizes the tag pass-through only.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  A/B/twiddle/in_tag valid this cycle.
- in_ready  out  1  block accepts input this cycle.
- a  in  2*word_size  operand A, packed {real, imag}.
- b  in  2*word_size  operand B, packed {real, imag}.
- twiddle  in  2*word_size  W, packed {real, imag} (same packing as ROM output).
- in_tag  in  $clog2(N)  sample index, carried alongside data.
- out_valid  out  1  outputs valid.
- out_ready  in  1  downstream accepts output.
- x0  out  2*word_size  (A + W·B)/2, packed {real, imag}.
- x1  out  2*word_size  (A − W·B)/2, packed {real, imag}.
- out_tag  out  $clog2(N)  in_tag delayed with its data.

Behaviour:
- Three register stages, each with a valid bit: S1, S2, S3.
  - S1: register A, B, W, tag.
  - S2: four signed products br·wr, bi·wi, br·wi, bi·wr (2·word_size bits each); register A.
  - S3: compute the W·B components, then the scaled sum and difference into the output registers.
- Latency: exactly 3 cycles from accepted input to out_valid when unstalled. Throughput: 1 per cycle.
- Global stall: advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - Input accepted iff in_valid && in_ready.
  - When advance=0, all stages hold; x0/x1/out_tag remain stable while out_valid && !out_ready.
  - Bubbles are not compressed.
- W·B real = br·wr − bi·wi; W·B imag = br·wi + bi·wr.
  - Each is a (2·word_size+1)-bit sum.
  - Add rounding constant 2^(word_size−2), then arithmetic shift right by word_size−1.
  - Narrow to word_size bits (saturate or wrap; see Optional Feature).
- Output: each component = (a_c ± wb_c + 1) >>> 1, computed in word_size+1 bits. The result always fits word_size bits.
- Reset:
  - All valid bits, x0, x1 and out_tag go to 0.
  - Reset mid-operation discards in-flight data.
  - in_ready is 1 in the first cycle after reset.
- Simultaneous in_valid with rst: reset wins and the input is dropped.
- No internal state beyond the pipeline registers.

Optional Feature:
- Macro BFLY_SAT_EN.
- Defined: W·B components outside [−2^(word_size−1), 2^(word_size−1)−1] after rounding clamp to the nearest bound.
- Undefined: keep the low word_size bits (two's-complement wrap).
- No other behaviour differs.

Decomposition:
- Shared package fft_pkg holds:
  - complex packing helpers (re/im field extraction);
  - the rounding constant and saturate function;
  - default WORD_SIZE and N, reused by the ROM, controller and butterfly.
- One natural sub-module: cmplx_mult (S1→S2 products plus rounding/narrowing, latency 2, driven by the shared advance). The butterfly adds the add/sub/scale stage around it.

Test Plan (word_size=16):
- W=(0x7FFF,0x0000), A=(0x1000,0), B=(0x0800,0), out_ready=1 → after 3 cycles x0=(0x0C00,0x0000), x1=(0x0400,0x0000), out_tag equals in_tag.
- W=(0x0000,0x8000), A=(0x1000,0), B=(0x0800,0) → x0=(0x0800,0xFC00), x1=(0x0800,0x0400).
- W=(0x5A82,0x5A82), A=0, B=(0x7FFF,0x8000):
  - with BFLY_SAT_EN → x0.real=0x4000;
  - without → x0.real=0xDA82;
  - both → x0.imag=0x0000.
- Stream 8 inputs with out_ready low for cycles 5–7 → in_ready low while the output is full and held; no data lost, duplicated or reordered; out_tag sequence 0..7 intact.
- Assert rst for 1 cycle with 3 items in flight → out_valid=0, x0=x1=0 the next cycle; no stale output afterwards; new input emerges 3 cycles after acceptance.
- Random A/B/W for 1000 vectors against a bit-exact reference model of the rounding/scaling rules, with random out_ready toggling → all outputs match.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT datapath (twiddle ROM, stage
// controller, butterfly).
//   - WORD_SIZE / N defaults and the derived widths
//   - complex packing helpers: {real, imag}, each Q1.(WORD_SIZE-1)
//   - W*B rounding constant and the saturating narrow function
// Build macro BFLY_SAT_EN selects saturating (defined) or wrapping
// (undefined) narrowing of the W*B components in cmplx_mult.
package fft_pkg;
    localparam int WORD_SIZE = 16;
    localparam int N         = 32;
    localparam int TAG_W     = $clog2(N);
    localparam int CW        = 2 * WORD_SIZE;      // packed complex word
    localparam int PW        = 2 * WORD_SIZE;      // one real product
    localparam int SW        = 2 * WORD_SIZE + 1;  // sum/difference of two products
    localparam int HW        = WORD_SIZE + 1;      // butterfly add/sub width

    // Half an LSB of the Q1.(WORD_SIZE-1) result, applied before the >>> (WORD_SIZE-1)
    localparam logic signed [SW-1:0] RND_C = SW'(2 ** (WORD_SIZE - 2));

    typedef logic signed [WORD_SIZE-1:0] comp_t;
    typedef logic        [CW-1:0]        cplx_t;

    // Payload that travels alongside the multiplier stages
    typedef struct packed {
        cplx_t            a;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic comp_t re(input cplx_t c);
        return comp_t'(c[CW-1:WORD_SIZE]);
    endfunction

    function automatic comp_t im(input cplx_t c);
        return comp_t'(c[WORD_SIZE-1:0]);
    endfunction

    // Clamp a rounded/shifted value to the WORD_SIZE signed range. The value
    // fits when every bit from the sign position of the narrow word upward agrees.
    function automatic comp_t sat(input logic signed [SW-1:0] v);
        logic [SW-WORD_SIZE:0] hi;
        hi = v[SW-1:WORD_SIZE-1];
        if (&hi || ~|hi) return v[WORD_SIZE-1:0];
        return v[SW-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
    endfunction
endpackage

// File: rtl/fft_butterfly_if.sv
// fft_butterfly_if: valid/ready streaming bus of the butterfly.
//   Input side : in_valid, in_ready, a, b, twiddle, in_tag
//   Output side: out_valid, out_ready, x0, x1, out_tag
// Modports: slave (the butterfly), master (the producer/consumer driving it).
interface fft_butterfly_if;
    import fft_pkg::*;

    logic             in_valid;
    logic             in_ready;
    cplx_t            a;
    cplx_t            b;
    cplx_t            twiddle;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    cplx_t            x0;
    cplx_t            x1;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, a, b, twiddle, in_tag, out_ready,
        output in_ready, out_valid, x0, x1, out_tag
    );

    modport master (
        output in_valid, a, b, twiddle, in_tag, out_ready,
        input  in_ready, out_valid, x0, x1, out_tag
    );
endinterface

// File: rtl/fft_butterfly_cmplx_mult.sv
// cmplx_mult: W*B complex multiply, latency 2 under the shared advance.
//   S1 registers B and W, S2 registers the four signed products; the
//   combine, round and narrow to WORD_SIZE run combinationally after S2.
// Ports:
//   clk   : clock
//   i_adv : pipeline advance (global stall when low)
//   i_b   : operand B {re, im}
//   i_w   : twiddle W {re, im}
//   o_wb  : W*B {re, im}, rounded and narrowed
// Narrowing: saturating with BFLY_SAT_EN defined, two's-complement wrap otherwise.
module cmplx_mult
    import fft_pkg::*;
(
    input  logic  clk,
    input  logic  i_adv,
    input  cplx_t i_b,
    input  cplx_t i_w,
    output cplx_t o_wb
);
    cplx_t                r_b, r_w;
    logic signed [PW-1:0] r_rr, r_ii, r_ri, r_ir;
    logic signed [SW-1:0] w_re_sum, w_im_sum, w_re_sh, w_im_sh;
    comp_t                w_re, w_im;

    // Data registers only; validity is tracked by the caller's valid pipe
    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_b  <= i_b;
            r_w  <= i_w;
            r_rr <= PW'(re(r_b)) * PW'(re(r_w));
            r_ii <= PW'(im(r_b)) * PW'(im(r_w));
            r_ri <= PW'(re(r_b)) * PW'(im(r_w));
            r_ir <= PW'(im(r_b)) * PW'(re(r_w));
        end
    end

    assign w_re_sum = SW'(r_rr) - SW'(r_ii) + RND_C;
    assign w_im_sum = SW'(r_ri) + SW'(r_ir) + RND_C;
    assign w_re_sh  = w_re_sum >>> (WORD_SIZE - 1);
    assign w_im_sh  = w_im_sum >>> (WORD_SIZE - 1);

`ifdef BFLY_SAT_EN
    assign w_re = sat(w_re_sh);
    assign w_im = sat(w_im_sh);
`else
    assign w_re = w_re_sh[WORD_SIZE-1:0];
    assign w_im = w_im_sh[WORD_SIZE-1:0];
    // Upper bits are dropped by the wrap
    logic w_unused_hi;
    assign w_unused_hi = ^{w_re_sh[SW-1:WORD_SIZE], w_im_sh[SW-1:WORD_SIZE]};
`endif

    assign o_wb = {w_re, w_im};
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: pipelined radix-2 DIT butterfly, 3 stages, 1 result/cycle.
//   x0 = (A + W*B)/2, x1 = (A - W*B)/2, each component rounded half-up.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears valids, x0, x1, out_tag)
//   bus : fft_butterfly_if.slave (in_valid/in_ready/a/b/twiddle/in_tag,
//         out_valid/out_ready/x0/x1/out_tag)
// Build macro BFLY_SAT_EN: saturating W*B narrowing (see cmplx_mult).
module fft_butterfly
    import fft_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fft_butterfly_if.slave bus
);
    logic                 w_adv;
    logic [3:1]           r_vld_pipe;
    stage_t               r_s1, r_s2;
    cplx_t                w_wb;
    cplx_t                r_x0, r_x1;
    logic [TAG_W-1:0]     r_tag;
    logic signed [HW-1:0] w_s0_re, w_s0_im, w_s1_re, w_s1_im;
    logic                 w_unused_lsb;

    // Whole pipe moves together; it only stops while a result waits on the consumer
    assign w_adv         = !r_vld_pipe[3] || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld_pipe[3];
    assign bus.x0        = r_x0;
    assign bus.x1        = r_x1;
    assign bus.out_tag   = r_tag;

    cmplx_mult u_mult (
        .clk   (clk),
        .i_adv (w_adv),
        .i_b   (bus.b),
        .i_w   (bus.twiddle),
        .o_wb  (w_wb)
    );

    // A and tag ride alongside the two multiplier stages
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1 <= '{a: bus.a, tag: bus.in_tag};
            r_s2 <= r_s1;
        end
    end

    // (a +/- wb + 1) >>> 1 in WORD_SIZE+1 bits; bits [HW-1:1] are the result
    assign w_s0_re = HW'(re(r_s2.a)) + HW'(re(w_wb)) + HW'(1);
    assign w_s0_im = HW'(im(r_s2.a)) + HW'(im(w_wb)) + HW'(1);
    assign w_s1_re = HW'(re(r_s2.a)) - HW'(re(w_wb)) + HW'(1);
    assign w_s1_im = HW'(im(r_s2.a)) - HW'(im(w_wb)) + HW'(1);
    assign w_unused_lsb = ^{w_s0_re[0], w_s0_im[0], w_s1_re[0], w_s1_im[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_x0       <= '0;
            r_x1       <= '0;
            r_tag      <= '0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[2:1], bus.in_valid};
            r_x0       <= {w_s0_re[HW-1:1], w_s0_im[HW-1:1]};
            r_x1       <= {w_s1_re[HW-1:1], w_s1_im[HW-1:1]};
            r_tag      <= r_s2.tag;
        end
    end
endmodule

// File: tb/tb_fft_butterfly.sv
// tb_fft_butterfly: directed table vectors, stall/hold, mid-flight reset and
// 1000 random vectors against a longint model of the rounding/scaling rules.
module tb_fft_butterfly;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fft_butterfly_if bus();

    fft_butterfly dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]      x;     // {x0, x1}
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        cplx_t       a;
        cplx_t       b;
        cplx_t       w;
        logic [63:0] x;
    } vec_t;

    exp_t q[$];
    exp_t cur_exp;
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_err = 0;
    logic rdy_rand  = 1'b0;
    logic rdy_force = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] narrow(input longint v);
`ifdef BFLY_SAT_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    function automatic logic [63:0] model(input cplx_t a, input cplx_t b, input cplx_t w);
        longint ar, ai, br, bi, wr, wi, pr, pi, nr, ni, x0r, x0i, x1r, x1i;
        ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
        wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
        pr = (br * wr - bi * wi + 16384) >>> 15;
        pi = (br * wi + bi * wr + 16384) >>> 15;
        nr = longint'($signed(narrow(pr)));
        ni = longint'($signed(narrow(pi)));
        x0r = (ar + nr + 1) >>> 1;  x0i = (ai + ni + 1) >>> 1;
        x1r = (ar - nr + 1) >>> 1;  x1i = (ai - ni + 1) >>> 1;
        return {x0r[15:0], x0i[15:0], x1r[15:0], x1i[15:0]};
    endfunction

    // out_ready: copied at +2 after each edge so main-thread writes at +1 land the same cycle
    initial forever begin
        @(posedge clk);
        #2;
        bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Scoreboard: push on acceptance, pop and compare on output handshake
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL extra_output: got tag %0d expected none", bus.out_tag);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data", {bus.x0, bus.x1}, e.x);
                    chk("tag", 64'(bus.out_tag), 64'(e.tag));
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(cur_exp);
        end
    end

    task automatic send(input cplx_t a, input cplx_t b, input cplx_t w,
                        input logic [TAG_W-1:0] tag, input logic [63:0] x);
        logic acc;
        acc = 1'b0;
        bus.a = a; bus.b = b; bus.twiddle = w; bus.in_tag = tag;
        cur_exp = '{x: x, tag: tag};
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 (tag %0d)", tag);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] tag);
        cplx_t a, b, w;
        a = $urandom; b = $urandom; w = $urandom;
        send(a, b, w, tag, model(a, b, w));
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 60 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    // Input accepted in cycle c: out_valid low in c+1, c+2, high in c+3
    task automatic latency(input string nm);
        @(negedge clk); chk(nm, 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk(nm, 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk(nm, 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] held;
        tbl[0] = '{32'h1000_0000, 32'h0800_0000, 32'h7FFF_0000, {32'h0C00_0000, 32'h0400_0000}};
        tbl[1] = '{32'h1000_0000, 32'h0800_0000, 32'h0000_8000, {32'h0800_FC00, 32'h0800_0400}};
`ifdef BFLY_SAT_EN
        tbl[2] = '{32'h0000_0000, 32'h7FFF_8000, 32'h5A82_5A82, {32'h4000_0000, 32'hC001_0001}};
`else
        tbl[2] = '{32'h0000_0000, 32'h7FFF_8000, 32'h5A82_5A82, {32'hDA82_0000, 32'h257F_0001}};
`endif
        tbl[3] = '{32'h7FFF_8000, 32'h0000_0000, 32'h7FFF_0000, {32'h4000_C000, 32'h4000_C000}};
        tbl[4] = '{32'h0000_0000, 32'h0800_1000, 32'h0000_7FFF, {32'hF800_0400, 32'h0800_FC00}};
        tbl[5] = '{32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_0000, {32'h0000_0000, 32'h7FFF_0000}};

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.twiddle = '0; bus.in_tag = '0;
        cur_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_x0", 64'(bus.x0), 64'd0);
        chk("rst_x1", 64'(bus.x1), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed table; the first vector also measures latency
        send(tbl[0].a, tbl[0].b, tbl[0].w, TAG_W'(0), tbl[0].x);
        latency("latency");
        for (int i = 1; i < 6; i++) send(tbl[i].a, tbl[i].b, tbl[i].w, TAG_W'(i), tbl[i].x);
        drain("table_drain");

        // Stream of 8 with out_ready low during cycles 5..7 of the stream
        rdy_force = 1'b1;
        fork
            for (int i = 0; i < 8; i++) send_rand(TAG_W'(i));
            begin
                repeat (5) @(posedge clk);
                #1 rdy_force = 1'b0;
                @(negedge clk);
                chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                chk("stall_tag", 64'(bus.out_tag), 64'd2);
                held = {bus.x0, bus.x1};
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    chk("stall_hold", {bus.x0, bus.x1}, held);
                    chk("stall_hold_tag", 64'(bus.out_tag), 64'd2);
                end
                @(posedge clk);
                #1 rdy_force = 1'b1;
            end
        join
        drain("stall_drain");

        // Reset with three items in flight, plus an input offered during reset
        rdy_force = 1'b0;
        for (int k = 0; k < 3; k++) send_rand(TAG_W'(20 + k));
        bus.a = $urandom; bus.b = $urandom; bus.twiddle = $urandom; bus.in_tag = TAG_W'(31);
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("inflight_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0; rdy_force = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_x0", 64'(bus.x0), 64'd0);
        chk("mid_rst_x1", 64'(bus.x1), 64'd0);
        chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("no_stale", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(tbl[1].a, tbl[1].b, tbl[1].w, TAG_W'(7), tbl[1].x);
        latency("post_rst_latency");
        drain("post_rst_drain");

        // Random vectors with random out_ready and occasional input bubbles
        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send_rand(TAG_W'(i));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_vec++; n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
